// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared request widths, request struct and clog2 helper
//
// Purpose: common definitions used by the request queue and the SPI serializer
//   so that both sides agree on opcode/address widths.
// Contents:
//   CTRL_ADDRW   default address width
//   CTRL_OPCODEW default opcode width
//   req_t        packed {opcode, addr} request at the default widths
//   clog2()      ceiling log2, usable in constant expressions
package ctrl_pkg;

  localparam int CTRL_ADDRW   = 8;
  localparam int CTRL_OPCODEW = 2;

  typedef struct packed {
    logic [CTRL_OPCODEW-1:0] opcode;
    logic [CTRL_ADDRW-1:0]   addr;
  } req_t;

  // Number of bits needed to encode values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/request_queue_mem.sv
// rtl/request_queue_mem.sv - request queue storage, 1 sync write / 1 async read
//
// Purpose: DEPTH x W register file holding queued requests. No reset; contents
//   are only meaningful where the pointer logic says an entry is occupied.
// Ports:
//   clk    in  1   core clock
//   we     in  1   write enable
//   waddr  in  AW  write index
//   wdata  in  W   write data
//   raddr  in  AW  read index
//   rdata  out W   read data (combinational)
module request_queue_mem
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CTRL_OPCODEW + CTRL_ADDRW,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/request_queue.sv
// rtl/request_queue.sv - FWFT request FIFO in front of the SPI serializer
//
// Purpose: buffers {opcode, addr} requests from control logic and presents the
//   head entry first-word-fall-through over valid/ready. Sticky overflow flags
//   a request offered while full (that request is dropped).
// Optional feature: define REQUEST_QUEUE_BYPASS_EN to let a request offered to
//   an empty queue appear on the output in the same cycle; if consumed that
//   cycle it is never written into storage.
// Ports:
//   clk, rst                          core clock, async active-high reset
//   in_valid/in_ready                 producer handshake (in_ready = !full)
//   in_opcode/in_addr                 request fields
//   out_valid/out_ready               consumer handshake (out_valid = !empty)
//   out_opcode/out_addr               head request (combinational read)
//   count, full, empty                occupancy and decoded flags
//   overflow, clr_overflow            sticky drop flag and its clear
module request_queue
  import ctrl_pkg::*;
#(
  parameter int ADDRW   = CTRL_ADDRW,
  parameter int OPCODEW = CTRL_OPCODEW,
  parameter int DEPTH   = 4,
  localparam int CW     = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPCODEW-1:0] in_opcode,
  input  logic [ADDRW-1:0]   in_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPCODEW-1:0] out_opcode,
  output logic [ADDRW-1:0]   out_addr,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  input  logic               clr_overflow
);

  localparam int PW = clog2(DEPTH);
  localparam int W  = OPCODEW + ADDRW;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  head_data;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

`ifdef REQUEST_QUEUE_BYPASS_EN
  // Empty queue with a request on offer: forward it straight through. When the
  // consumer takes it in the same cycle the storage is left untouched.
  logic bypass;
  assign bypass    = empty && in_valid;
  assign out_valid = !empty || bypass;
  assign {out_opcode, out_addr} = bypass ? {in_opcode, in_addr} : head_data;
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = !empty;
  assign {out_opcode, out_addr} = head_data;
  assign push      = in_valid && in_ready;
`endif

  // Pop only ever drains a stored entry; a bypassed request never reaches here.
  assign pop = !empty && out_ready;

  request_queue_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_opcode, in_addr}),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // A drop in the same cycle as a clear keeps the flag set.
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clr_overflow)     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// tb/tb_request_queue.sv - self-checking bench for request_queue
module tb_request_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_opcode;
  logic [7:0] in_addr;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_opcode;
  logic [7:0] out_addr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;

  int tests = 0;
  int fails = 0;

  request_queue #(.ADDRW(8), .OPCODEW(2), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_addr      (in_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_addr     (out_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of requests plus the sticky flag.
  logic [9:0] m_q[$];
  logic       m_ovf;

  always @(posedge clk or posedge rst) begin
    logic was_full;
    logic was_empty;
    logic do_push;
    logic do_pop;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full  = (m_q.size() == 4);
      was_empty = (m_q.size() == 0);
      do_pop    = !was_empty && out_ready;
      do_push   = in_valid && !was_full;
`ifdef REQUEST_QUEUE_BYPASS_EN
      if (was_empty && in_valid && out_ready) do_push = 1'b0;
`endif
      if (in_valid && was_full) m_ovf = 1'b1;
      else if (clr_overflow)    m_ovf = 1'b0;
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back({in_opcode, in_addr});
    end
  end

  // Per-cycle comparison against the model, plus a log of what the DUT hands out.
  logic [7:0] popped[$];

  always @(negedge clk) begin
    logic       exp_valid;
    logic [9:0] exp_data;
    if (!rst) begin
      exp_valid = (m_q.size() != 0);
      exp_data  = exp_valid ? m_q[0] : 10'h0;
`ifdef REQUEST_QUEUE_BYPASS_EN
      if (!exp_valid && in_valid) begin
        exp_valid = 1'b1;
        exp_data  = {in_opcode, in_addr};
      end
`endif
      check("m_out_valid", 32'(out_valid), 32'(exp_valid));
      check("m_count",     32'(count),     32'(m_q.size()));
      check("m_full",      32'(full),      32'(m_q.size() == 4));
      check("m_empty",     32'(empty),     32'(m_q.size() == 0));
      check("m_in_ready",  32'(in_ready),  32'(m_q.size() != 4));
      check("m_overflow",  32'(overflow),  32'(m_ovf));
      if (exp_valid) check("m_out_data", 32'({out_opcode, out_addr}), 32'(exp_data));
      if (out_valid && out_ready) popped.push_back(out_addr);
    end
  end

  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a,
                      input logic rdy, input logic clr);
    in_valid     = v;
    in_opcode    = op;
    in_addr      = a;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_opcode = 0; in_addr = 0; out_ready = 0; clr_overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single push, held under backpressure.
    step(1'b1, 2'b10, 8'hA5, 1'b0, 1'b0);
    check("t2_valid", 32'(out_valid), 1);
    check("t2_opcode", 32'(out_opcode), 32'h2);
    check("t2_addr", 32'(out_addr), 32'hA5);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("t2_hold_addr", 32'(out_addr), 32'hA5);
    end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    check("t2_drained", 32'(empty), 1);

    // Fill to full; 5th request dropped.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'(i), 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 3) begin
        check("t3_count4", 32'(count), 4);
        check("t3_full", 32'(full), 1);
        check("t3_in_ready", 32'(in_ready), 0);
        check("t3_no_ovf_yet", 32'(overflow), 0);
      end
    end
    check("t3_ovf", 32'(overflow), 1);
    check("t3_count_kept", 32'(count), 4);
    check("t3_head", 32'(out_addr), 32'h10);

    // One pop -> count 3, then reset mid-cycle.
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    check("t1_count3", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    check("t1_count", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_out_valid", 32'(out_valid), 0);
    check("t1_ovf", 32'(overflow), 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Overflow: set wins over a simultaneous clear, then a plain clear.
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 2'b01, 8'h99, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 1);
    step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 0);
    // Full with out_ready: no pass-through, in_ready stays low this cycle.
    in_valid = 1; in_addr = 8'h77; out_ready = 1; clr_overflow = 0;
    #1;
    check("full_no_passthru", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("full_drop_ovf", 32'(overflow), 1);
    check("full_pop_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
    check("flush_empty", 32'(empty), 1);

    // Wrap: hold count at 2 while streaming addresses 0x00..0x13.
    popped.delete();
    step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
    for (int i = 2; i < 20; i++) begin
      step(1'b1, 2'b11, 8'(i), 1'b1, 1'b0);
      check("t4_count2", 32'(count), 2);
    end
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    check("t4_pop_count", 32'(popped.size()), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      check("t4_order", 32'(popped[i]), 32'(i));

    // Serializer backpressure: slow out_ready pulses.
    popped.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 8'hA0 + 8'(i), 1'b0, 1'b0);
    repeat (8) idle();
    check("t5_held", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
      check("t5_one_pop", 32'(count), 32'(2 - i));
      repeat (3) idle();
    end
    check("t5_pops", 32'(popped.size()), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check("t5_order", 32'(popped[i]), 32'hA0 + 32'(i));

    // Offer to an empty queue with the consumer ready.
    in_valid = 1; in_opcode = 2'b01; in_addr = 8'h3C; out_ready = 1; clr_overflow = 0;
    #1;
`ifdef REQUEST_QUEUE_BYPASS_EN
    check("t6_byp_valid", 32'(out_valid), 1);
    check("t6_byp_addr", 32'(out_addr), 32'h3C);
    @(posedge clk);
    #1;
    check("t6_byp_count", 32'(count), 0);
`else
    check("t6_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check("t6_count", 32'(count), 1);
`endif
    idle();
    repeat (2) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
